// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial subtractor a - b with borrow/overflow/zero flags
// Optional macro BIT_SERIAL_SUB_SATURATE_EN: saturate diff to the signed limit on overflow.

module bit_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             bin;
   logic [CW-1:0]    cnt;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             bout;
   logic             last_bit;
   logic             raw_ovf;
   logic [WIDTH-1:0] final_diff;
   logic [WIDTH-1:0] emit_diff;

   // Full-subtractor cell on the current LSBs plus final-result assembly
   always_comb begin
      a_bit      = a_sh[0];
      b_bit      = b_sh[0];
      d_bit      = a_bit ^ b_bit ^ bin;
      bout       = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
      last_bit   = (state == BUSY) && (cnt == LAST_BIT);
      final_diff = {d_bit, res_sh[WIDTH-1:1]};
      // On the final bit, bin is the borrow into the MSB and bout the borrow out of it
      raw_ovf    = bin ^ bout;
`ifdef BIT_SERIAL_SUB_SATURATE_EN
      // a_bit holds the minuend sign on the final bit: 0 means positive overflow
      if (raw_ovf)
         emit_diff = a_bit ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         emit_diff = final_diff;
`else
      emit_diff  = final_diff;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready = (state == IDLE);
      done  = (state == DONE);
   end

   // Operand shifters, borrow flop, bit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         bin      <= 1'b0;
         cnt      <= '0;
         diff     <= '0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  bin    <= 1'b0;
                  cnt    <= '0;
               end
            end
            BUSY: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= final_diff;
               bin    <= bout;
               cnt    <= cnt + 1'b1;
               // Outputs change only here, so partial results never appear
               if (last_bit) begin
                  diff     <= emit_diff;
                  borrow   <= bout;
                  overflow <= raw_ovf;
                  zero     <= ~|emit_diff;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - scoreboard bench for bit_serial_subtractor

module tb_bit_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         overflow;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;
   logic         zero;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];

   bit_serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .ready(ready), .done(done), .diff(diff), .borrow(borrow),
      .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      logic [W:0] wide;
      wide       = {1'b0, av} - {1'b0, bv};
      e.diff     = wide[W-1:0];
      e.borrow   = (av < bv);
      e.overflow = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
`ifdef BIT_SERIAL_SUB_SATURATE_EN
      if (e.overflow)
         e.diff = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      e.zero     = (e.diff == '0);
      return e;
   endfunction

   // Full operation: push expectation, start, wait for done, pop and compare
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
      exp_t e;
      int   lat;
      bit   seen;
      exp_q.push_back(model(av, bv));
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~av; b = ~bv;
      total++;
      if (ready !== 1'b0) begin
         bad++; $display("FAIL %s ready_after_start got=%b want=0", name, ready);
      end
      seen = 0; lat = 0;
      for (int n = 1; n <= W + 4; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin seen = 1; lat = n; break; end
      end
      e = exp_q.pop_front();
      total++;
      if (!seen || lat != W) begin
         bad++; $display("FAIL %s done_latency got=%0d seen=%0d want=%0d", name, lat, seen, W);
      end
      total++;
      if (diff !== e.diff || borrow !== e.borrow || overflow !== e.overflow || zero !== e.zero) begin
         bad++;
         $display("FAIL %s result got diff=%h b=%b o=%b z=%b want diff=%h b=%b o=%b z=%b",
                  name, diff, borrow, overflow, zero, e.diff, e.borrow, e.overflow, e.zero);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         bad++; $display("FAIL %s after_done got done=%b ready=%b want done=0 ready=1", name, done, ready);
      end
      total++;
      if (diff !== e.diff || zero !== e.zero) begin
         bad++; $display("FAIL %s hold got diff=%h z=%b want diff=%h z=%b", name, diff, zero, e.diff, e.zero);
      end
   endtask

   task automatic check_reset_vals(input string name);
      total++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0 ||
          overflow !== 1'b0 || zero !== 1'b0) begin
         bad++;
         $display("FAIL %s got ready=%b done=%b diff=%h b=%b o=%b z=%b want ready=1 done=0 diff=00 b=0 o=0 z=0",
                  name, ready, done, diff, borrow, overflow, zero);
      end
   endtask

   task automatic count_dones(input int cycles, output int cnt);
      cnt = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) cnt++;
      end
   endtask

   task automatic test_reset();
      int dc;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("reset_state");
      // start and rst on the same edge: reset wins
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h11;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check_reset_vals("start_with_rst");
      count_dones(W + 4, dc);
      total++;
      if (dc != 0) begin
         bad++; $display("FAIL start_with_rst_done got=%0d want=0", dc);
      end
   endtask

   task automatic test_vectors();
      run_op(8'h05, 8'h03, "sub_05_03");
      run_op(8'h03, 8'h05, "sub_03_05");
      run_op(8'h80, 8'h01, "sub_80_01");
      run_op(8'h7F, 8'hFF, "sub_7F_FF");
      run_op(8'hFF, 8'h00, "sub_FF_00");
      run_op(8'h00, 8'hFF, "sub_00_FF");
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   dc;
      exp_q.push_back(model(8'h5A, 8'h5A));
      @(negedge clk);
      a = 8'h5A; b = 8'h5A; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a = 8'hFF; b = 8'h00; start = 1'b1;
      dc = 0;
      for (int n = 0; n < W + 6; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done === 1'b1) begin
            dc++;
            if (dc == 1) begin
               e = exp_q.pop_front();
               total++;
               if (diff !== e.diff || zero !== e.zero || borrow !== e.borrow || overflow !== e.overflow) begin
                  bad++;
                  $display("FAIL ignore_start_result got diff=%h z=%b want diff=%h z=%b",
                           diff, zero, e.diff, e.zero);
               end
            end
         end
      end
      total++;
      if (dc != 1) begin
         bad++; $display("FAIL ignore_start_done_count got=%0d want=1", dc);
      end
   endtask

   task automatic test_reset_abort();
      int dc;
      @(negedge clk);
      a = 8'h10; b = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_vals("abort_reset_vals");
      count_dones(W + 4, dc);
      total++;
      if (dc != 0) begin
         bad++; $display("FAIL abort_no_done got=%0d want=0", dc);
      end
      run_op(8'h10, 8'h01, "after_abort");
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] av, bv;
      for (int i = 0; i < 8; i++) begin
         av = W'($urandom_range(0, 255));
         bv = W'($urandom_range(0, 255));
         run_op(av, bv, "random");
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Sequential LSB-first bit-serial subtractor computing `a - b` one bit per clock through a single full-subtractor cell with a registered borrow. It is the inverse-operation counterpart to the team's gate-level full adder with overflow. It sits in the arithmetic datapath where area matters more than latency, and reports unsigned borrow, signed overflow and zero flags. Operands are accepted with a start/ready handshake, and the result is announced with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range is 2 or more.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  WIDTH  minuend; captured on an accepted start.
- `b`  in  WIDTH  subtrahend; captured on an accepted start.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `diff`  out  WIDTH  result `a - b` mod 2^WIDTH.
- `borrow`  out  1  unsigned borrow out of the MSB (`a < b` unsigned).
- `overflow`  out  1  signed two's-complement overflow.
- `zero`  out  1  `diff` == 0.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `ready`=1.
  - `start`=1 loads `a` and `b` into shift registers, clears the borrow flop and bit counter, and moves to BUSY.
- BUSY, per cycle on bit i (LSB first):
  - `d = a_i ^ b_i ^ bin`
  - `bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)`
  - `d` shifts into the result register from the MSB side. Operands shift right. `bin <= bout`.
  - After WIDTH bit-cycles, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE.
- Flags are computed on the final bit:
  - `borrow` = final `bout`.
  - `overflow` = (borrow into MSB) XOR (borrow out of MSB). This is equivalent to `a[MSB] != b[MSB] && diff[MSB] != a[MSB]`.
  - `zero` = NOR of the final `diff`.
- `diff`, `borrow`, `overflow` and `zero` update only on the transition into DONE, and hold through IDLE until the next result. Partial results are never visible on the outputs.
- `start` in BUSY or DONE is ignored; no queuing.
- `a` and `b` may change freely after acceptance.

## Timing
- Reset values: `ready`=1, `done`=0, `diff`=0, `borrow`=0, `overflow`=0, `zero`=0. Internal state and counter are cleared.
- `start` accepted at edge k: `ready`=0 after k. Bits are processed on edges k+1 … k+WIDTH.
- `done`=1 during the cycle after edge k+WIDTH, and results are valid in that same cycle. `ready` returns to 1 after edge k+WIDTH+1.
- Start-to-start throughput is WIDTH+2 cycles.
- `rst` has priority over everything. Asserting it mid-BUSY or in DONE aborts the operation, forces all reset values on the next edge, and produces no `done` pulse.
- `start` and `rst` asserted on the same edge: reset wins, and the operand is not captured.
- Counter width is `$clog2(WIDTH+1)`; it must not wrap before WIDTH.

## Configuration
- Macro `BIT_SERIAL_SUB_SATURATE_EN`.
- Defined: when `overflow`=1, `diff` is replaced by the signed saturation value.
  - Positive overflow (`a[MSB]`=0) gives `0` followed by all 1s (0x7F for WIDTH=8).
  - Negative overflow gives `1` followed by all 0s (0x80).
  - `borrow` and `overflow` still report raw values; `zero` reflects the emitted `diff`.
- Undefined: `diff` is always the raw modular result.

## Test plan
- 0x05 − 0x03, accepted at edge k: `done` in the cycle after edge k+8; `diff`=0x02, `borrow`=0, `overflow`=0, `zero`=0; `ready` back to 1 one cycle later.
- 0x03 − 0x05: `diff`=0xFE, `borrow`=1, `overflow`=0.
- 0x80 − 0x01: `overflow`=1, `borrow`=0. `diff`=0x7F without the macro, 0x80 with `BIT_SERIAL_SUB_SATURATE_EN`.
- 0x7F − 0xFF: `overflow`=1, `borrow`=1. `diff`=0x80 without the macro, 0x7F with it.
- 0x5A − 0x5A: `diff`=0x00, `zero`=1. A second `start` pulsed 3 cycles into BUSY is ignored: exactly one `done`, and operands are unchanged.
- Start 0x10 − 0x01, assert `rst` at bit-cycle 4: no `done`, all outputs at reset values, `ready`=1. A new 0x10 − 0x01 then completes with `diff`=0x0F.
